// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM pipeline stage (master) and the memory (slave).
// The request is level-held by the master; the memory answers with a one-cycle ack.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues aligned loads/stores on the dmem bus, stalls upstream
// while waiting, aborts on timeout or misalignment, and registers the WB result.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        zero_in,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        mem_to_reg_in,
  input  logic        is_branch_in,
  input  logic [31:0] pc_branch_in,
  input  logic [4:0]  regD_in,
  mem_stage_if.master dmem,
  output logic        stall,
  output logic        RegW_en_mem,
  output logic [4:0]  mem_regD,
  output logic [31:0] regFromMem,
  output logic        WB_EN,
  output logic [4:0]  wb_regD,
  output logic [31:0] wb_data,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        err_misalign,
  output logic        err_timeout
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr, r_wdata, r_br_tgt;
  logic        r_we, r_wb_en, r_load_wb, r_br_tk;
  logic [4:0]  r_regD;

  logic        r_WB_EN, r_br_taken, r_err_mis, r_err_to;
  logic [4:0]  r_wb_regD;
  logic [31:0] r_wb_data, r_br_target;

  logic        w_access, w_aligned, w_load, w_capture, w_stall, w_set_mis, w_set_to;
  logic        w_wb_en_nx, w_bt_nx;
  logic [4:0]  w_regD_nx;
  logic [31:0] w_data_nx, w_btgt_nx;

  assign w_access  = mem_r_en_in | mem_w_en_in;
  assign w_aligned = (alu_result[1:0] == 2'b00);

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_capture  = 1'b0;
    w_stall    = 1'b0;
    w_set_mis  = 1'b0;
    w_set_to   = 1'b0;
    w_wb_en_nx = wb_en_in;
    w_regD_nx  = regD_in;
    w_data_nx  = alu_result;
    w_bt_nx    = is_branch_in & zero_in;
    w_btgt_nx  = pc_branch_in;
    case (r_state)
      S_IDLE: begin
        if (!w_access) begin
          w_load = 1'b1;
        end else if (w_aligned) begin
          w_capture = 1'b1;
          w_stall   = 1'b1;
          w_next    = S_WAIT;
        end else begin
          w_load     = 1'b1;
          w_wb_en_nx = 1'b0;
          w_bt_nx    = 1'b0;
          w_set_mis  = 1'b1;
        end
      end
      S_WAIT: begin
        w_regD_nx = r_regD;
        w_bt_nx   = r_br_tk;
        w_btgt_nx = r_br_tgt;
        w_data_nx = r_addr;
        // An ack in the timeout cycle still counts as a normal completion
        if (dmem.dmem_ack) begin
          w_load     = 1'b1;
          w_wb_en_nx = r_wb_en;
          w_data_nx  = r_load_wb ? dmem.dmem_rdata : r_addr;
          w_next     = S_IDLE;
        end else if (r_cnt == LP_LAST) begin
          w_load     = 1'b1;
          w_wb_en_nx = 1'b0;
          w_set_to   = 1'b1;
          w_next     = S_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_wb_en     <= 1'b0;
      r_load_wb   <= 1'b0;
      r_regD      <= '0;
      r_br_tk     <= 1'b0;
      r_br_tgt    <= '0;
      r_WB_EN     <= 1'b0;
      r_wb_regD   <= '0;
      r_wb_data   <= '0;
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
      r_err_mis   <= 1'b0;
      r_err_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && w_next == S_WAIT) r_cnt <= r_cnt + 8'd1;
      else                                       r_cnt <= '0;
      if (w_capture) begin
        r_addr    <= alu_result;
        r_wdata   <= store_data;
        r_we      <= mem_w_en_in;
        r_wb_en   <= wb_en_in;
        r_load_wb <= mem_r_en_in & ~mem_w_en_in & mem_to_reg_in;
        r_regD    <= regD_in;
        r_br_tk   <= is_branch_in & zero_in;
        r_br_tgt  <= pc_branch_in;
      end
      if (w_load) begin
        r_WB_EN     <= w_wb_en_nx;
        r_wb_regD   <= w_regD_nx;
        r_wb_data   <= w_data_nx;
        r_br_taken  <= w_bt_nx;
        r_br_target <= w_btgt_nx;
      end
      if (w_set_mis) r_err_mis <= 1'b1;
      if (w_set_to)  r_err_to  <= 1'b1;
    end
  end

  // Stall is gated by reset so it drops immediately, not on the next edge
  assign stall            = w_stall & reset;
  assign dmem.dmem_req    = (r_state == S_WAIT);
  assign dmem.dmem_we     = r_we;
  assign dmem.dmem_addr   = r_addr;
  assign dmem.dmem_wdata  = r_wdata;

  assign RegW_en_mem   = wb_en_in;
  assign mem_regD      = regD_in;
  assign regFromMem    = alu_result;
  assign WB_EN         = r_WB_EN;
  assign wb_regD       = r_wb_regD;
  assign wb_data       = r_wb_data;
  assign branch_taken  = r_br_taken;
  assign branch_target = r_br_target;
  assign err_misalign  = r_err_mis;
  assign err_timeout   = r_err_to;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: each operation is predicted at transaction level
// (stall/request cycle counts, writeback result, sticky errors) and compared.
module tb_mem_stage;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] alu_result = '0, store_data = '0, pc_branch_in = '0;
  logic        zero_in = 0, wb_en_in = 0, mem_r_en_in = 0, mem_w_en_in = 0;
  logic        mem_to_reg_in = 0, is_branch_in = 0;
  logic [4:0]  regD_in = '0;
  logic        stall, RegW_en_mem, WB_EN, branch_taken, err_misalign, err_timeout;
  logic [4:0]  mem_regD, wb_regD;
  logic [31:0] regFromMem, wb_data, branch_target;

  int n_vec = 0;
  int n_err = 0;
  logic exp_mis = 0, exp_to = 0;

  mem_stage_if dmem_if ();

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .alu_result(alu_result), .store_data(store_data), .zero_in(zero_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .mem_to_reg_in(mem_to_reg_in), .is_branch_in(is_branch_in),
    .pc_branch_in(pc_branch_in), .regD_in(regD_in),
    .dmem(dmem_if.master),
    .stall(stall), .RegW_en_mem(RegW_en_mem), .mem_regD(mem_regD), .regFromMem(regFromMem),
    .WB_EN(WB_EN), .wb_regD(wb_regD), .wb_data(wb_data),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Caller is just past a falling edge; the op's inputs are driven immediately.
  // ack_at: cycle index (0 = the IDLE cycle) at which the memory pulses ack; -1 = never.
  task automatic run_op(input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pcb,
                        input logic [4:0] rd, input logic wb, input logic re, input logic we,
                        input logic m2r, input logic br, input logic z,
                        input int ack_at, input logic [31:0] rdata);
    logic acc, mis, chk_data, chk_br;
    int e_st, e_rq, n_st, n_rq, c;
    logic e_wb, done;
    logic [31:0] e_data;
    acc = re | we;
    mis = acc && (alu[1:0] != 2'b00);
    chk_data = 1; chk_br = 1;
    e_wb = wb; e_data = alu; e_st = 0; e_rq = 0;
    if (mis) begin
      e_wb = 0; chk_data = 0; exp_mis = 1;
    end else if (acc && ack_at >= 1 && ack_at <= T) begin
      e_st = ack_at; e_rq = ack_at;
      e_data = (re && !we && m2r) ? rdata : alu;
    end else if (acc) begin
      e_st = T; e_rq = T; e_wb = 0; chk_data = 0; chk_br = 0; exp_to = 1;
    end

    alu_result = alu; store_data = sd; pc_branch_in = pcb; regD_in = rd;
    wb_en_in = wb; mem_r_en_in = re; mem_w_en_in = we; mem_to_reg_in = m2r;
    is_branch_in = br; zero_in = z;
    n_st = 0; n_rq = 0; c = 0; done = 0;
    while (!done) begin
      dmem_if.dmem_ack   = (c == ack_at);
      dmem_if.dmem_rdata = (c == ack_at) ? rdata : $urandom();
      #1;
      check_val("fwd_wb_en", {31'd0, RegW_en_mem}, {31'd0, wb});
      check_val("fwd_regD", {27'd0, mem_regD}, {27'd0, rd});
      check_val("fwd_data", regFromMem, alu);
      if (dmem_if.dmem_req) begin
        n_rq++;
        check_val("dmem_addr", dmem_if.dmem_addr, alu);
        check_val("dmem_we", {31'd0, dmem_if.dmem_we}, {31'd0, we});
        if (we) check_val("dmem_wdata", dmem_if.dmem_wdata, sd);
      end
      if (stall) n_st++;
      else done = 1;
      if (!done && c > 300) begin
        check_val("stall_bound", 32'd1, 32'd0);
        done = 1;
      end
      if (!done) begin
        @(negedge clk);
        c++;
      end
    end
    @(negedge clk);
    dmem_if.dmem_ack = 0;
    #1;
    check_val("stall_cycles", n_st, e_st);
    check_val("req_cycles", n_rq, e_rq);
    check_val("WB_EN", {31'd0, WB_EN}, {31'd0, e_wb});
    if (chk_data) begin
      check_val("wb_regD", {27'd0, wb_regD}, {27'd0, rd});
      check_val("wb_data", wb_data, e_data);
    end
    if (chk_br) begin
      check_val("branch_taken", {31'd0, branch_taken}, {31'd0, (br & z & ~mis)});
      if (!mis) check_val("branch_target", branch_target, pcb);
    end
    check_val("err_misalign", {31'd0, err_misalign}, {31'd0, exp_mis});
    check_val("err_timeout", {31'd0, err_timeout}, {31'd0, exp_to});
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_req"}, {31'd0, dmem_if.dmem_req}, 32'd0);
    check_val({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check_val({tag, "_we"}, {31'd0, dmem_if.dmem_we}, 32'd0);
    check_val({tag, "_addr"}, dmem_if.dmem_addr, 32'd0);
    check_val({tag, "_wdata"}, dmem_if.dmem_wdata, 32'd0);
    check_val({tag, "_WB_EN"}, {31'd0, WB_EN}, 32'd0);
    check_val({tag, "_wb_regD"}, {27'd0, wb_regD}, 32'd0);
    check_val({tag, "_wb_data"}, wb_data, 32'd0);
    check_val({tag, "_bt"}, {31'd0, branch_taken}, 32'd0);
    check_val({tag, "_btgt"}, branch_target, 32'd0);
    check_val({tag, "_err_mis"}, {31'd0, err_misalign}, 32'd0);
    check_val({tag, "_err_to"}, {31'd0, err_timeout}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, sd, pcb;
    logic re, we;
    int ack_at;
    dmem_if.dmem_ack = 0;
    dmem_if.dmem_rdata = '0;
    // Aligned load presented during reset: stall must stay low
    alu_result = 32'h40; mem_r_en_in = 1;
    #17;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1;

    run_op(32'h10, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0, -1, 0);
    run_op(32'h100, 0, 32'h800, 5'd9, 1, 1, 0, 1, 0, 0, 4, 32'hDEADBEEF);
    run_op(32'h104, 32'h55, 0, 5'd3, 1, 1, 1, 1, 0, 0, 2, 32'h1234_5678);
    run_op(32'h200, 0, 32'h440, 5'd4, 1, 0, 0, 0, 1, 1, -1, 0);
    run_op(32'h102, 0, 0, 5'd6, 1, 1, 0, 1, 1, 1, -1, 0);
    run_op(32'h300, 0, 0, 5'd8, 1, 1, 0, 1, 0, 0, -1, 0);
    run_op(32'h304, 0, 32'h900, 5'd10, 1, 1, 0, 1, 1, 1, 4, 32'hCAFE_F00D);
    run_op(32'h20, 0, 0, 5'd11, 1, 0, 0, 0, 0, 0, 0, 32'hBAD0_BAD0);

    for (int i = 0; i < 150; i++) begin
      a = $urandom(); sd = $urandom(); pcb = $urandom();
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      re = $urandom_range(0, 1); we = $urandom_range(0, 1);
      ack_at = $urandom_range(0, 7) - 1;
      run_op(a, sd, pcb, 5'($urandom()), 1'($urandom()), re, we, 1'($urandom()),
             1'($urandom()), 1'($urandom()), ack_at, $urandom());
    end

    // Reset in the middle of a WAIT, then a stray ack after release
    alu_result = 32'h500; mem_r_en_in = 1; mem_w_en_in = 0; wb_en_in = 1;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 0;
    exp_mis = 0; exp_to = 0;
    #1;
    check_reset_state("midwait");
    @(negedge clk);
    reset = 1;
    run_op(32'h77, 0, 0, 5'd7, 1, 0, 0, 0, 0, 0, 0, 32'hBAD0_0BAD);
    run_op(32'h78, 0, 0, 5'd2, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0_0BAD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
